// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD configuration sequencer.
// Holds the panel ID codes, the FSM encoding and the per-panel display timing sets.
package lcd_pkg;

  // Panel ID codes as presented on the strap pins {M2,M1,M0}
  localparam logic [2:0] ID_4342 = 3'd0;
  localparam logic [2:0] ID_7084 = 3'd1;
  localparam logic [2:0] ID_7016 = 3'd2;
  localparam logic [2:0] ID_4384 = 3'd4;
  localparam logic [2:0] ID_1018 = 3'd5;

  // Sequencer states
  localparam logic [2:0] ST_SETTLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE   = 3'd1;
  localparam logic [2:0] ST_LATCH    = 3'd2;
  localparam logic [2:0] ST_CLK_WAIT = 3'd3;
  localparam logic [2:0] ST_RUN      = 3'd4;

  typedef struct packed {
    logic [10:0] h_disp;
    logic [10:0] h_sync;
    logic [10:0] h_back;
    logic [10:0] h_total;
    logic [10:0] v_disp;
    logic [10:0] v_sync;
    logic [10:0] v_back;
    logic [10:0] v_total;
  } lcd_timing_t;

  function automatic logic id_supported(input logic [2:0] code);
    return (code == ID_4342) || (code == ID_7084) || (code == ID_7016) ||
           (code == ID_4384) || (code == ID_1018);
  endfunction

  // Unsupported codes get the 7084 set, matching the ID they are remapped to
  function automatic lcd_timing_t id_timing(input logic [2:0] code);
    lcd_timing_t t;
    case (code)
      ID_4342: t = '{11'd480,  11'd41,  11'd2,   11'd525,  11'd272, 11'd10, 11'd2,  11'd286};
      ID_7016: t = '{11'd1024, 11'd20,  11'd140, 11'd1344, 11'd600, 11'd3,  11'd20, 11'd635};
      ID_4384: t = '{11'd800,  11'd128, 11'd88,  11'd1056, 11'd480, 11'd2,  11'd33, 11'd525};
      ID_1018: t = '{11'd1280, 11'd10,  11'd80,  11'd1440, 11'd800, 11'd3,  11'd10, 11'd823};
      default: t = '{11'd800,  11'd128, 11'd88,  11'd1056, 11'd480, 11'd2,  11'd33, 11'd525};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lcd_id_sync.sv
// Two-flop synchronizer bringing the strap pins and the rescan request into clk.
module lcd_id_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] id_pins,
  input  logic       rescan,
  output logic [2:0] id_pins_s,
  output logic       rescan_s
);

  logic [3:0] stage1_q, stage2_q;

  // Two back-to-back capture stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= {rescan, id_pins};
      stage2_q <= stage1_q;
    end
  end

  assign id_pins_s = stage2_q[2:0];
  assign rescan_s  = stage2_q[3];

endmodule

// File: rtl/lcd_id_cfg.sv
// LCD configuration sequencer: settles, samples and debounces the panel ID straps,
// latches the panel ID and its timing set, and sequences the pixel-domain reset.
// Optional macro LCD_ID_RESCAN_EN: a rescan pulse in RUN re-runs detection.
module lcd_id_cfg
  import lcd_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 50000,
  parameter int unsigned SAMPLE_GAP = 1000,
  parameter int unsigned SAMPLE_NUM = 4,
  parameter int unsigned MAX_TRY    = 64,
  parameter int unsigned SWITCH_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  id_pins,
  input  logic        rescan,
  output logic [15:0] lcd_id,
  output logic        id_valid,
  output logic        id_err,
  output logic        pix_rst_n,
  output logic [10:0] h_disp,
  output logic [10:0] h_sync,
  output logic [10:0] h_back,
  output logic [10:0] h_total,
  output logic [10:0] v_disp,
  output logic [10:0] v_sync,
  output logic [10:0] v_back,
  output logic [10:0] v_total
);

  // Cycle counters only reach PARAM-1; match/try counters must hold the PARAM value itself
  localparam int unsigned SettleW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned GapW    = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int unsigned SwitchW = (SWITCH_CYC > 1) ? $clog2(SWITCH_CYC) : 1;
  localparam int unsigned MatchW  = $clog2(SAMPLE_NUM + 1);
  localparam int unsigned TryW    = $clog2(MAX_TRY + 1);

  logic [2:0] pins_s;
  logic       rescan_s;

  lcd_id_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_pins   (id_pins),
    .rescan    (rescan),
    .id_pins_s (pins_s),
    .rescan_s  (rescan_s)
  );

  logic [2:0]         state_q, state_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [SwitchW-1:0] sw_cnt_q, sw_cnt_d;
  logic [MatchW-1:0]  match_cnt_q, match_cnt_d;
  logic [TryW-1:0]    try_cnt_q, try_cnt_d;
  logic [2:0]         cand_q, cand_d;
  logic [15:0]        lcd_id_q, lcd_id_d;
  lcd_timing_t        timing_q, timing_d;
  logic               id_err_q, id_err_d;
  logic               run_q, run_d;
  logic               err_set;
  logic [2:0]         code;

`ifndef LCD_ID_RESCAN_EN
  logic unused_rescan;
  assign unused_rescan = rescan_s;
`endif

  // Next-state, counter and latch logic
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sw_cnt_d     = sw_cnt_q;
    match_cnt_d  = match_cnt_q;
    try_cnt_d    = try_cnt_q;
    cand_d       = cand_q;
    lcd_id_d     = lcd_id_q;
    timing_d     = timing_q;
    err_set      = 1'b0;
    code         = id_supported(cand_q) ? cand_q : ID_7084;

    unique case (state_q)
      ST_SETTLE: begin
        if (settle_cnt_q == SettleW'(SETTLE_CYC - 1)) state_d = ST_SAMPLE;
        else settle_cnt_d = settle_cnt_q + SettleW'(1);
      end
      ST_SAMPLE: begin
        gap_cnt_d = (gap_cnt_q == GapW'(SAMPLE_GAP - 1)) ? '0 : gap_cnt_q + GapW'(1);
        // A sample is taken whenever the gap counter sits at zero, incl. the entry cycle
        if (gap_cnt_q == '0) begin
          try_cnt_d = try_cnt_q + TryW'(1);
          if ((try_cnt_q != '0) && (pins_s == cand_q)) begin
            match_cnt_d = match_cnt_q + MatchW'(1);
          end else begin
            cand_d      = pins_s;
            match_cnt_d = MatchW'(1);
          end
          if (match_cnt_d == MatchW'(SAMPLE_NUM)) begin
            state_d = ST_LATCH;
          end else if (try_cnt_d == TryW'(MAX_TRY)) begin
            cand_d  = ID_7084;
            err_set = 1'b1;
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        lcd_id_d = {13'd0, code};
        timing_d = id_timing(code);
        err_set  = !id_supported(cand_q);
        state_d  = ST_CLK_WAIT;
      end
      ST_CLK_WAIT: begin
        if (sw_cnt_q == SwitchW'(SWITCH_CYC - 1)) state_d = ST_RUN;
        else sw_cnt_d = sw_cnt_q + SwitchW'(1);
      end
      ST_RUN: begin
`ifdef LCD_ID_RESCAN_EN
        if (rescan_s) state_d = ST_SETTLE;
`else
        state_d = ST_RUN;
`endif
      end
      default: state_d = ST_SETTLE;
    endcase

    // Every counter restarts from zero on entry to any state
    if (state_d != state_q) begin
      settle_cnt_d = '0;
      gap_cnt_d    = '0;
      sw_cnt_d     = '0;
      match_cnt_d  = '0;
      try_cnt_d    = '0;
    end

    id_err_d = id_err_q | err_set;
    run_d    = (state_d == ST_RUN);
  end

  // State registers; outputs are registered so the pixel reset is glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= '0;
      gap_cnt_q    <= '0;
      sw_cnt_q     <= '0;
      match_cnt_q  <= '0;
      try_cnt_q    <= '0;
      cand_q       <= ID_7084;
      lcd_id_q     <= 16'd1;
      timing_q     <= id_timing(ID_7084);
      id_err_q     <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sw_cnt_q     <= sw_cnt_d;
      match_cnt_q  <= match_cnt_d;
      try_cnt_q    <= try_cnt_d;
      cand_q       <= cand_d;
      lcd_id_q     <= lcd_id_d;
      timing_q     <= timing_d;
      id_err_q     <= id_err_d;
      run_q        <= run_d;
    end
  end

  assign lcd_id    = lcd_id_q;
  assign id_valid  = run_q;
  assign pix_rst_n = run_q;
  assign id_err    = id_err_q;
  assign h_disp    = timing_q.h_disp;
  assign h_sync    = timing_q.h_sync;
  assign h_back    = timing_q.h_back;
  assign h_total   = timing_q.h_total;
  assign v_disp    = timing_q.v_disp;
  assign v_sync    = timing_q.v_sync;
  assign v_back    = timing_q.v_back;
  assign v_total   = timing_q.v_total;

endmodule

// File: tb/tb_lcd_id_cfg.sv
// Self-checking bench for lcd_id_cfg with shortened timing parameters.
module tb_lcd_id_cfg;

  localparam int unsigned SETTLE_CYC = 20;
  localparam int unsigned SAMPLE_GAP = 10;
  localparam int unsigned SAMPLE_NUM = 4;
  localparam int unsigned MAX_TRY    = 8;
  localparam int unsigned SWITCH_CYC = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  id_pins = 3'd0;
  logic        rescan = 1'b0;
  logic [15:0] lcd_id;
  logic        id_valid, id_err, pix_rst_n;
  logic [10:0] h_disp, h_sync, h_back, h_total, v_disp, v_sync, v_back, v_total;

  lcd_id_cfg #(
    .SETTLE_CYC (SETTLE_CYC),
    .SAMPLE_GAP (SAMPLE_GAP),
    .SAMPLE_NUM (SAMPLE_NUM),
    .MAX_TRY    (MAX_TRY),
    .SWITCH_CYC (SWITCH_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_pins   (id_pins),
    .rescan    (rescan),
    .lcd_id    (lcd_id),
    .id_valid  (id_valid),
    .id_err    (id_err),
    .pix_rst_n (pix_rst_n),
    .h_disp    (h_disp),
    .h_sync    (h_sync),
    .h_back    (h_back),
    .h_total   (h_total),
    .v_disp    (v_disp),
    .v_sync    (v_sync),
    .v_back    (v_back),
    .v_total   (v_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  pins;
    logic [15:0] id;
    logic        err;
    logic [10:0] hd, hs, hb, ht, vd, vs, vb, vt;
  } vec_t;

  vec_t vecs[8];
  int   n_vec = 0;
  int   n_err = 0;
  bit   stop_toggle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset(input logic [2:0] p);
    @(negedge clk);
    rst_n   = 1'b0;
    id_pins = p;
    rescan  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!id_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, " reached RUN"}, 32'(id_valid), 32'd1);
  endtask

  task automatic wait_id(input string name, input logic [15:0] id);
    int n = 0;
    while (lcd_id !== id && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, " id latched"}, 32'(lcd_id), 32'(id));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{3'd0, 16'd0, 1'b0, 11'd480, 11'd41, 11'd2, 11'd525, 11'd272, 11'd10, 11'd2, 11'd286};
    vecs[1] = '{3'd1, 16'd1, 1'b0, 11'd800, 11'd128, 11'd88, 11'd1056, 11'd480, 11'd2, 11'd33, 11'd525};
    vecs[2] = '{3'd2, 16'd2, 1'b0, 11'd1024, 11'd20, 11'd140, 11'd1344, 11'd600, 11'd3, 11'd20, 11'd635};
    vecs[3] = '{3'd3, 16'd1, 1'b1, 11'd800, 11'd128, 11'd88, 11'd1056, 11'd480, 11'd2, 11'd33, 11'd525};
    vecs[4] = '{3'd4, 16'd4, 1'b0, 11'd800, 11'd128, 11'd88, 11'd1056, 11'd480, 11'd2, 11'd33, 11'd525};
    vecs[5] = '{3'd5, 16'd5, 1'b0, 11'd1280, 11'd10, 11'd80, 11'd1440, 11'd800, 11'd3, 11'd10, 11'd823};
    vecs[6] = '{3'd6, 16'd1, 1'b1, 11'd800, 11'd128, 11'd88, 11'd1056, 11'd480, 11'd2, 11'd33, 11'd525};
    vecs[7] = '{3'd7, 16'd1, 1'b1, 11'd800, 11'd128, 11'd88, 11'd1056, 11'd480, 11'd2, 11'd33, 11'd525};

    // Stable pins from reset, one run per code
    for (int i = 0; i < 8; i++) begin
      apply_reset(vecs[i].pins);
      check($sformatf("v%0d reset lcd_id", i), 32'(lcd_id), 32'd1);
      check($sformatf("v%0d reset id_valid", i), 32'(id_valid), 32'd0);
      check($sformatf("v%0d reset pix_rst_n", i), 32'(pix_rst_n), 32'd0);
      check($sformatf("v%0d reset id_err", i), 32'(id_err), 32'd0);
      check($sformatf("v%0d reset h_total", i), 32'(h_total), 32'd1056);
      wait_valid($sformatf("v%0d", i));
      check($sformatf("v%0d lcd_id", i), 32'(lcd_id), 32'(vecs[i].id));
      check($sformatf("v%0d id_err", i), 32'(id_err), 32'(vecs[i].err));
      check($sformatf("v%0d pix_rst_n", i), 32'(pix_rst_n), 32'd1);
      check($sformatf("v%0d h_disp", i), 32'(h_disp), 32'(vecs[i].hd));
      check($sformatf("v%0d h_sync", i), 32'(h_sync), 32'(vecs[i].hs));
      check($sformatf("v%0d h_back", i), 32'(h_back), 32'(vecs[i].hb));
      check($sformatf("v%0d h_total", i), 32'(h_total), 32'(vecs[i].ht));
      check($sformatf("v%0d v_disp", i), 32'(v_disp), 32'(vecs[i].vd));
      check($sformatf("v%0d v_sync", i), 32'(v_sync), 32'(vecs[i].vs));
      check($sformatf("v%0d v_back", i), 32'(v_back), 32'(vecs[i].vb));
      check($sformatf("v%0d v_total", i), 32'(v_total), 32'(vecs[i].vt));
    end

    // Pixel reset release SWITCH_CYC cycles after the ID is latched
    apply_reset(3'b010);
    wait_id("switch", 16'd2);
    check("switch pix_rst_n low at latch", 32'(pix_rst_n), 32'd0);
    n = 0;
    while (!pix_rst_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("switch release delay", 32'(n), 32'(SWITCH_CYC));
    check("switch id_valid", 32'(id_valid), 32'd1);

    // Pins alternating at every sample: fall back after MAX_TRY samples
    apply_reset(3'b000);
    stop_toggle = 1'b0;
    fork
      while (!stop_toggle) begin
        repeat (SAMPLE_GAP) @(negedge clk);
        if (!stop_toggle) id_pins = id_pins ^ 3'b001;
      end
    join_none
    wait_valid("fallback");
    stop_toggle = 1'b1;
    check("fallback lcd_id", 32'(lcd_id), 32'd1);
    check("fallback id_err", 32'(id_err), 32'd1);
    check("fallback h_total", 32'(h_total), 32'd1056);
    repeat (SAMPLE_GAP + 2) @(negedge clk);

    // 101 for two samples, then 000: match count must restart
    apply_reset(3'b101);
    repeat (36) @(negedge clk);
    id_pins = 3'b000;
    wait_valid("restart");
    check("restart lcd_id", 32'(lcd_id), 32'd0);
    check("restart h_disp", 32'(h_disp), 32'd480);
    check("restart id_err", 32'(id_err), 32'd0);

    // Asynchronous reset during CLK_WAIT, then full re-run
    apply_reset(3'b010);
    wait_id("midrst", 16'd2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst lcd_id", 32'(lcd_id), 32'd1);
    check("midrst h_total", 32'(h_total), 32'd1056);
    check("midrst v_total", 32'(v_total), 32'd525);
    check("midrst pix_rst_n", 32'(pix_rst_n), 32'd0);
    check("midrst id_valid", 32'(id_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("midrst rerun");
    check("midrst rerun lcd_id", 32'(lcd_id), 32'd2);
    check("midrst rerun h_total", 32'(h_total), 32'd1344);

    // Rescan from RUN with new pins
    id_pins = 3'b101;
    repeat (3) @(negedge clk);
    rescan = 1'b1;
    n = 0;
    while (id_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) rescan = 1'b0;
    end
    rescan = 1'b0;
`ifdef LCD_ID_RESCAN_EN
    check("rescan drop latency", 32'(n), 32'd3);
    check("rescan pix_rst_n", 32'(pix_rst_n), 32'd0);
    check("rescan lcd_id held", 32'(lcd_id), 32'd2);
    wait_valid("rescan");
    check("rescan lcd_id", 32'(lcd_id), 32'd5);
    check("rescan h_total", 32'(h_total), 32'd1440);
`else
    check("rescan ignored id_valid", 32'(id_valid), 32'd1);
    check("rescan ignored pix_rst_n", 32'(pix_rst_n), 32'd1);
    repeat (SETTLE_CYC + 4 * SAMPLE_GAP) @(negedge clk);
    check("rescan ignored lcd_id", 32'(lcd_id), 32'd2);
    check("rescan ignored still valid", 32'(id_valid), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
